// File: rtl/booth_mult_seq_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
//   state_e       : controller states (IDLE/RUN/DONE)
//   booth_digit_e : recoded multiplier digit {0,+1,+2,-1,-2}
//   iters()       : Booth iterations needed for a given operand width
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_digit_e;

   // Operands are extended by two bits, so one extra digit is retired
   // beyond WIDTH/2; that top digit is what makes the unsigned case exact.
   function automatic int iters(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Handshake/data bundle between a requester and booth_mult_seq.
//   start, is_signed, multiplicand, multiplier : request side
//   busy, done, product_hi, product_lo        : response side
interface booth_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_hi;
   logic [WIDTH-1:0] product_lo;

   modport master (
      output start, is_signed, multiplicand, multiplier,
      input  busy, done, product_hi, product_lo
   );

   modport slave (
      input  start, is_signed, multiplicand, multiplier,
      output busy, done, product_hi, product_lo
   );
endinterface

// File: rtl/booth_mult_seq_encoder.sv
// Radix-4 Booth recoder (combinational).
//   triplet : {b[i+1], b[i], b[i-1]}
//   neg     : digit is negative
//   one     : |digit| == 1
//   two     : |digit| == 2
module booth_r4_encoder
   import mult_pkg::*;
(
   input  logic [2:0] triplet,
   output logic       neg,
   output logic       one,
   output logic       two
);

   booth_digit_e digit;

   always_comb begin
      digit = ZERO;
      unique case (triplet)
         3'b000:  digit = ZERO;
         3'b001:  digit = POS1;
         3'b010:  digit = POS1;
         3'b011:  digit = POS2;
         3'b100:  digit = NEG2;
         3'b101:  digit = NEG1;
         3'b110:  digit = NEG1;
         3'b111:  digit = ZERO;
         default: digit = ZERO;
      endcase
      neg = (digit == NEG1) || (digit == NEG2);
      one = (digit == POS1) || (digit == NEG1);
      two = (digit == POS2) || (digit == NEG2);
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, fixed latency of iters(WIDTH)+1
// edges from the accepting start edge to the done pulse.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : slave side of booth_mult_seq_if (start/operands in,
//           busy/done/product_hi/product_lo out, all registered)
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one Booth digit retired per cycle, counter counts down
// DONE  | product registered, done pulsed, back to IDLE
module booth_mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            clr_n,
   booth_mult_seq_if.slave bus
);

   localparam int ITERS = iters(WIDTH);
   localparam int AW    = WIDTH + 3;          // accumulator, holds +/-2M
   localparam int BW    = WIDTH + 2;          // extended multiplier
   localparam int PW    = AW + BW + 1;        // acc | multiplier | b[-1]
   localparam int CNT_W = $clog2(ITERS + 1);

   state_e           state, state_d;
   logic             load, step, finish;
   logic [PW-1:0]    preg;
   logic [AW-1:0]    mcand;
   logic [CNT_W-1:0] cnt;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] hi_q, lo_q;

   logic             neg, one, two;
   logic [AW-1:0]    pp, acc_sum;
   logic [PW-1:0]    preg_shift;
   logic [AW-1:0]    a_ext;
   logic [BW-1:0]    b_ext;

   booth_r4_encoder u_enc (
      .triplet (preg[2:0]),
      .neg     (neg),
      .one     (one),
      .two     (two)
   );

   assign a_ext = {{3{bus.is_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
   assign b_ext = {{2{bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};

   always_comb begin
      pp = '0;
      if (one)
         pp = mcand;
      else if (two)
         pp = {mcand[AW-2:0], 1'b0};
      if (neg)
         pp = ~pp + AW'(1);
      acc_sum    = preg[PW-1 -: AW] + pp;
      // Arithmetic shift keeps the accumulator sign while consumed
      // multiplier bits fall off the bottom.
      preg_shift = $signed({acc_sum, preg[BW:0]}) >>> 2;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1))
               state_d = DONE;
         end
         DONE: begin
            finish  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         preg   <= '0;
         mcand  <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= finish;
         if (load) begin
            preg   <= {{AW{1'b0}}, b_ext, 1'b0};
            mcand  <= a_ext;
            cnt    <= CNT_W'(ITERS);
            busy_q <= 1'b1;
         end
         if (step) begin
            preg <= preg_shift;
            cnt  <= cnt - CNT_W'(1);
         end
         if (finish) begin
            busy_q <= 1'b0;
            // bit 0 is the leftover b[-1] slot, so the product starts at bit 1
            hi_q   <= preg[2*WIDTH:WIDTH+1];
            lo_q   <= preg[WIDTH:1];
         end
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.product_hi = hi_q;
   assign bus.product_lo = lo_q;

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-4 Booth multiplier for the CPU datapath's MUL instruction path. It accepts two WIDTH-bit operands under a start/done handshake, supports signed and unsigned modes, and returns a 2*WIDTH-bit product split into HI/LO halves for the HI and LO registers. It retires two multiplier bits per cycle with fixed, data-independent latency.

## Interface
Parameters:
- WIDTH, 32, operand width; even, >= 4
- ITERS, WIDTH/2+1, derived localparam (not overridable); Booth iterations

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  reset; asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with the operands
- multiplicand  in  WIDTH  operand A, latched on accepted start
- multiplier  in  WIDTH  operand B, latched on accepted start
- busy  out  1  high from the accepted start edge until done is asserted
- done  out  1  one-cycle pulse; product valid
- product_hi  out  WIDTH  upper half of the product
- product_lo  out  WIDTH  lower half of the product

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when start=1, latch the operands and is_signed, clear the accumulator, and load the iteration counter with ITERS. Extend both operands to WIDTH+2 bits: sign-extend when is_signed=1, zero-extend when 0. Append a 0 below the multiplier LSB. Go to RUN.
- RUN, each cycle:
  - Encode the multiplier triplet {b[i+1],b[i],b[i-1]} to digit d in {0,+1,+2,-1,-2}.
  - Add d*M to the upper part of the accumulator. Form -M and -2M in two's complement at WIDTH+3 bits.
  - Arithmetic-shift the combined accumulator/multiplier register right by 2.
  - Decrement the counter. On the cycle the counter reaches 0, go to DONE.
- DONE: load product_hi/lo from the low 2*WIDTH bits of the result, assert done for this one cycle, then return to IDLE.
- product_hi/lo hold their value until the next DONE. They do not change during RUN.
- start is ignored while busy=1. It is not queued.
- A start seen in the IDLE cycle that follows DONE is accepted, so back-to-back operations are possible.
- Operand inputs may change freely after the accepting edge.
- Width rules:
  - The result is exact for every input pair in both modes. No overflow or truncation is reported.
  - The unsigned case works because the zero-extended top triplet always encodes to d >= 0.
- Reset (clr_n=0), at any time including mid-RUN:
  - Force IDLE.
  - busy=0, done=0, product_hi=0, product_lo=0.
  - Clear the counter and the accumulator.
  - The in-flight operation is discarded and no done is produced.

## Timing
- Start accepted at rising edge E0. Then busy=1 after E0.
- RUN occupies edges E1..E(ITERS). DONE is entered after E(ITERS).
- done=1 and the product is valid in the cycle after E(ITERS+1); busy falls at that same edge.
- Latency from the accepting edge to the done pulse: ITERS+1 edges. That is 18 cycles for WIDTH=32 and 6 for WIDTH=8.
- Minimum interval between accepted starts: ITERS+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - the Booth digit encoding type (ZERO, POS1, POS2, NEG1, NEG2)
  - a function iters(width) returning width/2+1
- One combinational sub-module, booth_r4_encoder. Input: a 3-bit triplet. Outputs: the digit's neg, one, and two selects. The main module instantiates it once.
- Everything else lives in booth_mult_seq: the counter, the accumulator/shift register, the adder, and the FSM.

## Test plan
- WIDTH=32, signed, -7 x 3 -> done after 18 cycles, product_hi=0xFFFFFFFF, product_lo=0xFFFFFFEB.
- WIDTH=32:
  - unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001
  - the same operands signed -> hi=0x00000000, lo=0x00000001
- WIDTH=32, signed, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. Also 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Handshake: hold start=1 for 30 cycles with new operands each cycle. Required:
  - exactly one done per ITERS+2 cycles
  - each product matches the operands present on its accepting edge
  - busy never drops mid-operation
- Pull clr_n low at RUN cycle 5 for one cycle. Required:
  - all outputs are 0 immediately (async)
  - no done pulse follows
  - the next start completes correctly with 5 x 6 -> lo=30, hi=0
- WIDTH=8: exhaustive 256x256 in both modes against a reference model. Every done arrives 6 cycles after its start edge.
